// File: rtl/kbd_pkg.sv
// Shared constants and helpers for the key event path.
// Consumers decode ev_code against the KEYn constants.
package kbd_pkg;

  localparam int NKEY   = 4;
  localparam int CODE_W = $clog2(NKEY);

  localparam logic [CODE_W-1:0] KEY0 = CODE_W'(0);
  localparam logic [CODE_W-1:0] KEY1 = CODE_W'(1);
  localparam logic [CODE_W-1:0] KEY2 = CODE_W'(2);
  localparam logic [CODE_W-1:0] KEY3 = CODE_W'(3);

  // Expects a one-hot or zero input; zero encodes to index 0.
  function automatic logic [CODE_W-1:0] onehot_to_idx(input logic [NKEY-1:0] oh);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NKEY; i++) begin
      if (oh[i]) idx = idx | CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/kbd_sync_fifo.sv
// Single-clock first-word fall-through FIFO with occupancy count.
// A write into a full FIFO is accepted when a read fires in the same cycle.
module kbd_sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             rd_fire;
  logic             wr_fire;

  assign rd_fire = rd_en && (count != '0);
  assign wr_fire = wr_en && ((count != CNT_W'(DEPTH)) || rd_fire);
  assign rd_data = mem[rd_ptr];

  // Memory is reset so the head reads as 0 while empty.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem    <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_fire) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_event_fifo.sv
// Captures key press pulses into pending flags and queues them as key codes.
// Fixed-priority arbitration (lowest key first), one FIFO write per cycle.
module kbd_event_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NKEY-1:0]   key_pulse,
  output logic              ev_valid,
  output logic [CODE_W-1:0] ev_code,
  input  logic              ev_ready,
  output logic [CNT_W-1:0]  ev_count,
  output logic              ovf,
  input  logic              ovf_clr
);

  logic [NKEY-1:0] pend;
  logic [NKEY-1:0] lowest;
  logic [NKEY-1:0] grant;
  logic            pop;
  logic            wr_ok;
  logic            drop;

  assign ev_valid = (ev_count != '0);
  assign pop      = ev_valid && ev_ready;
  assign wr_ok    = (ev_count < CNT_W'(DEPTH)) || pop;
  assign lowest   = pend & (~pend + NKEY'(1));
  assign grant    = wr_ok ? lowest : '0;
  // A repeat press of a key still waiting in pend is merged and lost.
  assign drop     = |(key_pulse & pend & ~grant);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend <= '0;
      ovf  <= 1'b0;
    end else begin
      pend <= (pend & ~grant) | key_pulse;
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  kbd_sync_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (|grant),
    .wr_data (onehot_to_idx(grant)),
    .rd_en   (pop),
    .rd_data (ev_code),
    .count   (ev_count)
  );

endmodule

// File: tb/tb_kbd_event_fifo.sv
// Directed bench for kbd_event_fifo with hand-computed expectations.
module tb_kbd_event_fifo;
  import kbd_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rstn;
  logic [NKEY-1:0]   key_pulse;
  logic              ev_valid;
  logic [CODE_W-1:0] ev_code;
  logic              ev_ready;
  logic [CNT_W-1:0]  ev_count;
  logic              ovf;
  logic              ovf_clr;

  int n_tests = 0;
  int n_fail  = 0;

  kbd_event_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .key_pulse (key_pulse),
    .ev_valid  (ev_valid),
    .ev_code   (ev_code),
    .ev_ready  (ev_ready),
    .ev_count  (ev_count),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NKEY-1:0] key_bit(input int k);
    logic [NKEY-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  logic [CODE_W-1:0] exp_q[$];
  logic [CODE_W-1:0] drain4 [9];

  initial begin
    rstn = 1'b0; key_pulse = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    check("rst_valid", ev_valid, 0);
    check("rst_count", ev_count, 0);
    check("rst_code",  ev_code, 0);
    check("rst_ovf",   ovf, 0);
    rstn = 1'b1;
    tick();

    // 1: single press, two-cycle latency, single pop
    key_pulse = 4'b0100; tick(); key_pulse = '0;
    check("t1_valid_k", ev_valid, 0);
    tick();
    check("t1_valid_k1", ev_valid, 1);
    check("t1_code", ev_code, KEY2);
    check("t1_count", ev_count, 1);
    check("t1_ovf", ovf, 0);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    check("t1_pop_valid", ev_valid, 0);
    check("t1_pop_count", ev_count, 0);

    // 2: simultaneous presses serialised lowest first
    key_pulse = 4'b1011; tick(); key_pulse = '0;
    tick(); check("t2_cnt1", ev_count, 1);
    tick(); check("t2_cnt2", ev_count, 2);
    tick(); check("t2_cnt3", ev_count, 3);
    tick(); check("t2_cnt_hold", ev_count, 3);
    ev_ready = 1'b1;
    check("t2_code0", ev_code, KEY0); tick();
    check("t2_code1", ev_code, KEY1); tick();
    check("t2_code3", ev_code, KEY3); tick();
    ev_ready = 1'b0;
    check("t2_empty", ev_valid, 0);

    // 3: fill FIFO, ninth press waits in pend
    for (int i = 0; i < 9; i++) begin
      key_pulse = key_bit(i % 4); tick();
    end
    key_pulse = '0; tick(); tick();
    check("t3_full", ev_count, 8);
    check("t3_ovf", ovf, 0);
    check("t3_head", ev_code, KEY0);
    ev_ready = 1'b1; tick(); ev_ready = 1'b0;
    check("t3_pop_refill", ev_count, 8);
    check("t3_head_after", ev_code, KEY1);
    tick();
    check("t3_still_full", ev_count, 8);

    // 4: repeat press of a pending key while full sets ovf
    key_pulse = 4'b0010; tick(); key_pulse = '0; tick();
    check("t4_no_ovf_yet", ovf, 0);
    key_pulse = 4'b0010; tick(); key_pulse = '0;
    check("t4_ovf_set", ovf, 1);
    drain4 = '{KEY1, KEY2, KEY3, KEY0, KEY1, KEY2, KEY3, KEY0, KEY1};
    ev_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t4_drain%0d_valid", i), ev_valid, 1);
      check($sformatf("t4_drain%0d_code", i), ev_code, drain4[i]);
      tick();
    end
    tick(); tick();
    check("t4_drained", ev_count, 0);
    ev_ready = 1'b0;
    check("t4_ovf_sticky", ovf, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("t4_ovf_clr", ovf, 0);

    // 5: streaming with ev_ready held high, pointers wrap
    ev_ready = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 30; i++) begin
      if (i < 20) begin
        key_pulse = key_bit(i % 4);
        exp_q.push_back(CODE_W'(i % 4));
      end else begin
        key_pulse = '0;
      end
      tick();
      n_tests++;
      assert (ev_count <= 2) else begin
        n_fail++;
        $error("FAIL t5_count_bound: observed %0d expected <=2", ev_count);
      end
      if (ev_valid) begin
        if (exp_q.size() == 0) begin
          check("t5_unexpected_event", ev_valid, 0);
        end else begin
          check($sformatf("t5_code%0d", i), ev_code, exp_q.pop_front());
        end
      end
    end
    key_pulse = '0;
    check("t5_all_seen", exp_q.size(), 0);
    check("t5_empty", ev_valid, 0);
    ev_ready = 1'b0;

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) begin
      key_pulse = key_bit(i % 4); tick();
    end
    key_pulse = 4'b0100; tick(); key_pulse = '0;
    check("t6_count5", ev_count, 5);
    #2 rstn = 1'b0; key_pulse = 4'b1000;
    #1;
    check("t6_rst_valid", ev_valid, 0);
    check("t6_rst_count", ev_count, 0);
    check("t6_rst_ovf", ovf, 0);
    tick(); tick();
    key_pulse = '0;
    #2 rstn = 1'b1;
    tick(); tick(); tick();
    check("t6_ignored_pulse", ev_valid, 0);
    key_pulse = 4'b0100; tick(); key_pulse = '0; tick();
    check("t6_new_valid", ev_valid, 1);
    check("t6_new_code", ev_code, KEY2);
    check("t6_new_count", ev_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
